// File: rtl/norm_issue_sched.sv
// ============================================================================
// Module      : norm_issue_sched
// Description : Issue scheduler for a shared FP32 / dual-lane FP16 normalizer.
//               Pairs FP16 operands and round-robins against FP32 requests.
//               Optional macro NORM_SCHED_TIMEOUT_EN enables the pairing timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package norm_issue_sched_pkg;
    typedef enum logic {
        FP32 = 1'b0,
        FP16 = 1'b1
    } fp_fmt_e;
endpackage

module norm_issue_sched
    import norm_issue_sched_pkg::*;
#(
    parameter int TAG_W        = 4,
    parameter int PAIR_TIMEOUT = 7
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in32_valid,
    output logic             in32_ready,
    input  logic [27:0]      in32_x,
    input  logic [TAG_W-1:0] in32_tag,

    input  logic             in16_valid,
    output logic             in16_ready,
    input  logic [13:0]      in16_x,
    input  logic [TAG_W-1:0] in16_tag,

    input  logic             flush,

    output fp_fmt_e          nrm_fmt,
    output logic [27:0]      nrm_x,
    input  logic [27:0]      nrm_r,
    input  logic [4:0]       nrm_cnt_h,
    input  logic [4:0]       nrm_cnt_l,

    output logic             res_valid,
    input  logic             res_ready,
    output fp_fmt_e          res_fmt,
    output logic [27:0]      res_r,
    output logic [4:0]       res_cnt_h,
    output logic [4:0]       res_cnt_l,
    output logic [TAG_W-1:0] res_tag_h,
    output logic [TAG_W-1:0] res_tag_l,
    output logic             res_lo_vld
);

    localparam logic [7:0] C_PAIR_TIMEOUT = 8'(PAIR_TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_e;

    state_e             r_state;
    logic [13:0]        r_hold_x;
    logic [TAG_W-1:0]   r_hold_tag;
    logic               r_pref16;

    logic               w_issue_ok;
    logic               w_timeout;
    logic               w_c32;
    logic               w_c16;
    logic               w_grant32;
    logic               w_grant16;
    logic               w_paired;
    logic               w_accept16;

    assign w_issue_ok = !res_valid || res_ready;
    assign w_c32      = in32_valid;
    assign w_c16      = (r_state == S_HOLD) && (in16_valid || w_timeout || flush);

    // Contention is resolved in favour of the class that lost the last grant.
    always_comb begin
        w_grant32 = 1'b0;
        w_grant16 = 1'b0;
        if (!rst && w_issue_ok) begin
            if (w_c32 && w_c16) begin
                w_grant16 = r_pref16;
                w_grant32 = !r_pref16;
            end else begin
                w_grant32 = w_c32;
                w_grant16 = w_c16;
            end
        end
    end

    assign w_paired   = w_grant16 && in16_valid;
    assign w_accept16 = !rst && (r_state == S_IDLE) && in16_valid && w_issue_ok;

    assign in32_ready = w_grant32;
    assign in16_ready = (r_state == S_IDLE) ? (!rst && w_issue_ok) : w_grant16;

    always_comb begin
        nrm_fmt = FP32;
        nrm_x   = '0;
        if (w_grant32) begin
            nrm_x = in32_x;
        end else if (w_grant16) begin
            nrm_fmt = FP16;
            nrm_x   = {r_hold_x, (in16_valid ? in16_x : 14'h0)};
        end
    end

`ifdef NORM_SCHED_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // Held at zero while idle so the count starts from zero on entry to HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_wait_cnt <= '0;
        end else if (!w_grant16 && (r_wait_cnt != C_PAIR_TIMEOUT)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    assign w_timeout = (r_state == S_HOLD) && (r_wait_cnt == C_PAIR_TIMEOUT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^C_PAIR_TIMEOUT;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_x   <= '0;
            r_hold_tag <= '0;
            r_pref16   <= 1'b0;
            res_valid  <= 1'b0;
            res_fmt    <= FP32;
            res_r      <= '0;
            res_cnt_h  <= '0;
            res_cnt_l  <= '0;
            res_tag_h  <= '0;
            res_tag_l  <= '0;
            res_lo_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept16) begin
                        r_state    <= S_HOLD;
                        r_hold_x   <= in16_x;
                        r_hold_tag <= in16_tag;
                    end
                end
                S_HOLD: begin
                    if (w_grant16) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A grant overwrites the result register even while it is being drained.
            if (w_grant32 || w_grant16) begin
                r_pref16   <= w_grant32;
                res_valid  <= 1'b1;
                res_fmt    <= nrm_fmt;
                res_r      <= nrm_r;
                res_cnt_h  <= nrm_cnt_h;
                res_cnt_l  <= nrm_cnt_l;
                res_tag_h  <= w_grant32 ? in32_tag : r_hold_tag;
                res_tag_l  <= w_paired ? in16_tag : '0;
                res_lo_vld <= w_paired;
            end else if (res_ready) begin
                res_valid  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/norm_issue_sched.md
NORM_ISSUE_SCHED -- requirements
Module: norm_issue_sched

Interface
REQ-001 Parameter TAG_W, default 4: width of each requester tag.
REQ-002 Parameter PAIR_TIMEOUT, default 7: cycles a lone held FP16 operand waits for a partner, 1..255.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in32_valid/in32_ready  input/output  1/1  FP32 request handshake.
REQ-006 in32_x, in32_tag  input  28/TAG_W  FP32 fraction with guard/round/sticky, plus tag.
REQ-007 in16_valid/in16_ready  input/output  1/1  FP16 request handshake.
REQ-008 in16_x, in16_tag  input  14/TAG_W  one 14-bit FP16 lane word, plus tag.
REQ-009 flush  input  1  forces a held lone FP16 operand to issue unpaired.
REQ-010 nrm_fmt, nrm_x  output  fp_fmt_e/28  drive the shared normalizer's fmt and X.
REQ-011 nrm_r, nrm_cnt_h, nrm_cnt_l  input  28/5/5  combinational normalizer R, Count_h, Count_l.
REQ-012 res_valid/res_ready  output/input  1/1  result handshake.
REQ-013 res_fmt, res_r, res_cnt_h, res_cnt_l  output  fp_fmt_e/28/5/5  registered normalizer result.
REQ-014 res_tag_h, res_tag_l, res_lo_vld  output  TAG_W/TAG_W/1  lane tags; res_lo_vld marks a valid FP16 low lane.

Function
REQ-015 The block SHALL have two hold states: IDLE (no FP16 held) and HOLD (one FP16 operand and tag in the hold register).
REQ-016 issue_ok SHALL equal !res_valid || res_ready; no issue occurs when issue_ok is 0.
REQ-017 In IDLE, in16_ready SHALL be 1; an accepted FP16 SHALL move the block to HOLD and SHALL NOT issue that cycle.
REQ-018 Candidate C32 = in32_valid; candidate C16 = HOLD && (in16_valid || timeout || flush).
REQ-019 When both candidates are present, the block SHALL grant round-robin, preferring the class not granted last; the pointer resets to prefer FP32.
REQ-020 An FP32 grant SHALL drive nrm_fmt=FP32, nrm_x=in32_x, set in32_ready=1, and capture res_tag_h=in32_tag, res_lo_vld=0.
REQ-021 An FP16 grant with in16_valid SHALL drive nrm_x={held, in16_x}, set in16_ready=1, res_tag_h=held tag, res_tag_l=in16_tag, res_lo_vld=1, and return to IDLE.
REQ-022 An FP16 grant without in16_valid (timeout or flush) SHALL drive nrm_x={held, 14'b0}, res_lo_vld=0, and return to IDLE.
REQ-023 Both FP16 grant cases SHALL drive nrm_fmt=FP16.
REQ-024 In HOLD, in16_ready SHALL be 1 only on an FP16 grant; in32_ready SHALL be 1 only on an FP32 grant.
REQ-025 When no grant occurs, nrm_fmt=FP32 and nrm_x=0.
REQ-026 The result register SHALL load nrm_r, nrm_cnt_h, nrm_cnt_l, fmt and tags on the grant cycle, with res_valid=1 the next cycle (latency 1 from grant).
REQ-027 With res_valid=1 and res_ready=0, all res_* outputs SHALL hold stable and both in*_ready SHALL be 0.
REQ-028 Simultaneous res_ready and a grant SHALL replace the result with no bubble.
REQ-029 flush in IDLE SHALL have no effect.

Reset
REQ-030 During rst, the state SHALL be IDLE, res_valid=0, all res_* data outputs=0, the timeout counter=0, and the round-robin pointer SHALL prefer FP32.
REQ-031 rst asserted in HOLD SHALL discard the held operand without issuing it.
REQ-032 A result pending at rst SHALL be dropped.

Configuration
REQ-033 Macro NORM_SCHED_TIMEOUT_EN, when defined, SHALL enable an 8-bit counter that clears on entry to HOLD, increments each HOLD cycle, and saturates at PAIR_TIMEOUT.
REQ-034 With NORM_SCHED_TIMEOUT_EN defined, timeout SHALL equal (counter==PAIR_TIMEOUT) and SHALL remain high until the FP16 grant.
REQ-035 With NORM_SCHED_TIMEOUT_EN undefined, timeout SHALL be constant 0 and a lone held operand SHALL leave HOLD only by pairing, flush, or rst.

Verification
REQ-036 FP32 x=28'h0000100, res_ready=1 -> next cycle res_valid=1, res_fmt=FP32, res_cnt_h=19, res_r=28'h8000000.
REQ-037 FP16 a=14'h0400 (tag 1) then b=14'h0001 (tag 2) -> one issue, nrm_x=28'h1000001, res_lo_vld=1, res_tag_h=1, res_tag_l=2.
REQ-038 Single FP16 with TIMEOUT_EN, PAIR_TIMEOUT=7 -> issue exactly 7 cycles after entering HOLD, low lane zero, res_lo_vld=0.
REQ-039 Continuous in32_valid plus a pending FP16 pair -> grants alternate FP32, FP16, FP32, and neither class starves.
REQ-040 res_ready=0 for 5 cycles with a result pending -> res_* stable, in32_ready=in16_ready=0; the next grant completes on the first res_ready cycle.
REQ-041 rst pulsed in HOLD -> the held operand is never emitted and in16_ready=1 the cycle after reset.
